// File: rtl/z80_io_uart.sv
// z80_io_uart: 8N1 serial port on the Z80 I/O bus with a small RX FIFO.
// BASE_ADDR+0: TX byte (write) / RX FIFO head (read).
// BASE_ADDR+1: status read {4'b0, framing_err, rx_overrun, tx_busy, rx_avail}.
// Optional: define Z80_IO_UART_IRQ_EN to add an active-low int_n output.
module z80_io_uart #(
  parameter logic [7:0] BASE_ADDR = 8'h10,
  parameter int         CLK_DIV   = 16,
  parameter int         RX_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iorq_n,
  input  logic       m1_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] port_addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
`ifdef Z80_IO_UART_IRQ_EN
  output logic       int_n,
`endif
  output logic       txd,
  input  logic       rxd
);
  localparam int         AW      = $clog2(RX_DEPTH);
  localparam int         CW      = AW + 1;
  localparam logic [7:0] STAT_A  = BASE_ADDR + 8'd1;
  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} st_e;

  // Bus decode; interrupt-acknowledge cycles (m1_n=0) never select us.
  logic is_data, is_stat, sel, rd_acc, wr_acc, wr_first, rd_end;
  logic rd_acc_q, wr_acc_q, rd_stat_q;
  assign is_data  = (port_addr == BASE_ADDR);
  assign is_stat  = (port_addr == STAT_A);
  assign sel      = ~iorq_n & m1_n & (is_data | is_stat);
  assign rd_acc   = sel & ~rd_n;
  assign wr_acc   = sel & ~wr_n;
  assign wr_first = wr_acc & ~wr_acc_q;
  assign rd_end   = rd_acc_q & ~rd_acc;

  // TX state
  st_e         tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_busy;

  // RX state
  st_e         rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_fall;
  logic        rx_push, ferr_set;

  // FIFO and flags
  logic [7:0]    fifo_q [RX_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          ovr_q, ferr_q, rx_avail, full, pop, do_push, ovr_set, flg_clr;

  assign tx_busy  = (tx_st_q != S_IDLE);
  assign rx_avail = (cnt_q != '0);
  assign full     = (cnt_q == CW'(RX_DEPTH));
  assign pop      = rd_end & ~rd_stat_q & rx_avail;
  assign flg_clr  = rd_end & rd_stat_q;
  assign do_push  = rx_push & (~full | pop);
  assign ovr_set  = rx_push & full & ~pop;
  assign rx_fall  = rx_prev_q & ~rx_s2_q;

  // Access history: edge detection for writes, end-of-read side effects.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_acc_q  <= 1'b0;
      wr_acc_q  <= 1'b0;
      rd_stat_q <= 1'b0;
    end else begin
      rd_acc_q <= rd_acc;
      wr_acc_q <= wr_acc;
      if (rd_acc) rd_stat_q <= is_stat;
    end
  end

  // Read data is combinational so it tracks the bus for the whole access.
  always_comb begin
    data_out = 8'h00;
    data_oe  = rd_acc;
    if (rd_acc) begin
      if (is_stat) data_out = {4'b0, ferr_q, ovr_q, tx_busy, rx_avail};
      else if (rx_avail) data_out = fifo_q[rptr_q];
    end
  end

  // TX state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st_q  <= S_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
    end
  end

  // TX next state: start/data/stop each CLK_DIV cycles; writes while busy drop.
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q + 16'd1;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    case (tx_st_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (wr_first && is_data) begin
          tx_sh_d = data_in;
          tx_st_d = S_START;
        end
      end
      S_START: if (tx_cnt_q == DIV_M1) begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        tx_st_d  = S_DATA;
      end
      S_DATA: if (tx_cnt_q == DIV_M1) begin
        tx_cnt_d = '0;
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_st_d = S_STOP;
      end
      S_STOP: if (tx_cnt_q == DIV_M1) begin
        tx_cnt_d = '0;
        tx_st_d  = S_IDLE;
      end
      default: tx_st_d = S_IDLE;
    endcase
  end

  // Line level follows state, so reset returns txd high the next cycle.
  always_comb begin
    case (tx_st_q)
      S_START: txd = 1'b0;
      S_DATA:  txd = tx_sh_q[0];
      default: txd = 1'b1;
    endcase
  end

  // RX synchronizer (idle-high preset) and RX state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= S_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
    end else begin
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
    end
  end

  // RX next state: half-bit start check rejects glitches, then mid-bit samples.
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q + 16'd1;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_push  = 1'b0;
    ferr_set = 1'b0;
    case (rx_st_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_st_d = S_START;
      end
      S_START: if (rx_cnt_q == HALF_M1) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt_q == DIV_M1) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
      end
      S_STOP: if (rx_cnt_q == DIV_M1) begin
        rx_cnt_d = '0;
        rx_st_d  = S_IDLE;
        if (rx_s2_q) rx_push = 1'b1;
        else         ferr_set = 1'b1;
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  // FIFO pointers/count and sticky flags; a same-cycle set beats the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (pop)     rptr_q <= rptr_q + AW'(1);
      if (do_push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !do_push) cnt_q <= cnt_q - CW'(1);
      ovr_q  <= (ovr_q  & ~flg_clr) | ovr_set;
      ferr_q <= (ferr_q & ~flg_clr) | ferr_set;
    end
  end

  // FIFO storage; contents only matter where the count says they are live.
  always_ff @(posedge clk) begin
    if (do_push) fifo_q[wptr_q] <= rx_sh_q;
  end

`ifdef Z80_IO_UART_IRQ_EN
  // Level interrupt while data is waiting, registered one cycle behind the FIFO.
  always_ff @(posedge clk) begin
    if (reset) int_n <= 1'b1;
    else       int_n <= ~rx_avail;
  end
`endif
endmodule

// File: tb/tb_z80_io_uart.sv
// Directed bench for z80_io_uart: a bus model drives the CPU side, a line model
// drives rxd, and a txd monitor decodes frames against a queue of expected bytes.
module tb_z80_io_uart;
  localparam int         DIV  = 16;
  localparam int         DEP  = 4;
  localparam logic [7:0] DATA = 8'h10;
  localparam logic [7:0] STAT = 8'h11;

  logic       clk = 1'b0;
  logic       reset, iorq_n, m1_n, rd_n, wr_n, rxd;
  logic [7:0] port_addr, data_in, data_out;
  logic       data_oe, txd;
`ifdef Z80_IO_UART_IRQ_EN
  logic       int_n;
`endif

  z80_io_uart #(.BASE_ADDR(8'h10), .CLK_DIV(DIV), .RX_DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n),
    .wr_n(wr_n), .port_addr(port_addr), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe),
`ifdef Z80_IO_UART_IRQ_EN
    .int_n(int_n),
`endif
    .txd(txd), .rxd(rxd));

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];
  logic       m_ovr = 1'b0, m_ferr = 1'b0, m_busy = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %02h want %02h", tag, obs, exp);
    end
  endtask

  // Read access held for cyc clocks; data must hold steady across it.
  task automatic io_rd(input logic [7:0] a, input int cyc, output logic [7:0] d);
    @(posedge clk); #1;
    iorq_n = 1'b0; rd_n = 1'b0; port_addr = a;
    #1 d = data_out;
    chk("rd_oe", {7'b0, data_oe}, 8'h01);
    repeat (cyc - 1) begin
      @(posedge clk); #2;
      chk("rd_stable", data_out, d);
    end
    @(posedge clk); #1;
    iorq_n = 1'b1; rd_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic io_wr(input logic [7:0] a, input logic [7:0] v);
    @(posedge clk); #1;
    iorq_n = 1'b0; wr_n = 1'b0; port_addr = a; data_in = v;
    @(posedge clk);
    @(posedge clk); #1;
    iorq_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic rd_status(input string tag);
    logic [7:0] d;
    io_rd(STAT, 1, d);
    chk(tag, d, {4'b0, m_ferr, m_ovr, m_busy, 1'(rx_exp.size() != 0)});
    m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic rd_data(input string tag, input int cyc);
    logic [7:0] d, e;
    e = (rx_exp.size() != 0) ? rx_exp.pop_front() : 8'h00;
    io_rd(DATA, cyc, d);
    chk(tag, d, e);
  endtask

  // One 8N1 frame on rxd; the model mirrors FIFO capacity and error flags.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      #1 rxd = fr[i];
      repeat (DIV) @(posedge clk);
    end
    #1 rxd = 1'b1;
    repeat (4) @(posedge clk);
    if (!stop) m_ferr = 1'b1;
    else if (rx_exp.size() < DEP) rx_exp.push_back(b);
    else m_ovr = 1'b1;
  endtask

  // txd monitor: samples mid-bit relative to the detected start edge.
  initial begin : txmon
    logic       last, act;
    int         cnt;
    logic [7:0] sh, e;
    last = 1'b1; act = 1'b0; cnt = 0; sh = '0;
    forever begin
      @(posedge clk); #2;
      if (reset) act = 1'b0;
      else if (!act) begin
        if (last && !txd) begin act = 1'b1; cnt = 0; end
      end else begin
        cnt++;
        if (cnt % DIV == DIV / 2) begin
          if (cnt / DIV == 0) chk("tx_start", {7'b0, txd}, 8'h00);
          else if (cnt / DIV <= 8) sh = {txd, sh[7:1]};
          else begin
            chk("tx_stop", {7'b0, txd}, 8'h01);
            e = (tx_exp.size() != 0) ? tx_exp.pop_front() : 8'hxx;
            chk("tx_byte", sh, e);
            act = 1'b0;
          end
        end
      end
      last = txd;
    end
  end

  initial begin
    logic [7:0] d;
    reset = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    rxd = 1'b1; port_addr = 8'h00; data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_txd", {7'b0, txd}, 8'h01);
    chk("rst_oe", {7'b0, data_oe}, 8'h00);
    chk("rst_dout", data_out, 8'h00);
`ifdef Z80_IO_UART_IRQ_EN
    chk("rst_int", {7'b0, int_n}, 8'h01);
`endif
    rd_status("rst_stat");

    // TX frame and busy flag
    tx_exp.push_back(8'h55);
    io_wr(DATA, 8'h55);
    m_busy = 1'b1;
    repeat (40) @(posedge clk);
    rd_status("tx_busy");
    m_busy = 1'b0;
    repeat (130) @(posedge clk);
    rd_status("tx_idle");

    // RX frame
    send_byte(8'hA3, 1'b1);
    rd_status("rx_avail");
`ifdef Z80_IO_UART_IRQ_EN
    chk("irq_on", {7'b0, int_n}, 8'h00);
`endif
    rd_data("rx_a3", 1);
    rd_status("rx_empty");
`ifdef Z80_IO_UART_IRQ_EN
    chk("irq_off", {7'b0, int_n}, 8'h01);
`endif

    // Overrun: five bytes into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    rd_status("ovr_stat");
    for (int i = 0; i < 4; i++) rd_data("ovr_data", 1);
    rd_status("ovr_clr");
    rd_data("empty_rd", 1);

    // Framing error
    send_byte(8'h7E, 1'b0);
    rd_status("ferr_stat");
    rd_status("ferr_clr");

    // Glitch rejection
    @(posedge clk); #1 rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (30) @(posedge clk);
    rd_status("glitch");

    // Multi-cycle read pops once; IACK has no effect
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rd_data("long_rd", 4);
    @(posedge clk); #1;
    iorq_n = 1'b0; m1_n = 1'b0; rd_n = 1'b0; port_addr = DATA;
    #1;
    chk("iack_oe", {7'b0, data_oe}, 8'h00);
    chk("iack_dout", data_out, 8'h00);
    repeat (2) @(posedge clk);
    #1 iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1;
    @(posedge clk);
    rd_status("one_left");
    rd_data("rx_22", 1);
    rd_status("drained");

    // Reset mid-frame, then busy-write drop
    io_wr(DATA, 8'h12);
    repeat (38) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_txd", {7'b0, txd}, 8'h01);
    reset = 1'b0;
    rd_status("rst_mid_stat");
    tx_exp.push_back(8'h34);
    io_wr(DATA, 8'h34);
    io_wr(DATA, 8'h56);
    repeat (180) @(posedge clk);
    chk("tx_drained", 8'(tx_exp.size()), 8'h00);
    rd_status("final_stat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/z80_io_uart.md
Name: z80_io_uart

Overview:
- Serial I/O peripheral on the Z80 I/O bus of the tv80s CPU top level.
- Consumes the core's iorq_n/rd_n/wr_n/m1_n, low address byte and write data.
- Returns read data to the CPU data-in mux.
- Provides an 8N1 asynchronous TX/RX line with a small RX FIFO for the console link.

Parameters:
- BASE_ADDR, 8'h10: I/O port base; the block decodes BASE_ADDR (data) and BASE_ADDR+1 (status).
- CLK_DIV, 16: clk cycles per serial bit; legal range 4..65535.
- RX_DEPTH, 4: RX FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- iorq_n  in  1  CPU I/O request, active low
- m1_n  in  1  CPU M1; an I/O cycle with m1_n=0 is an interrupt acknowledge and is ignored
- rd_n  in  1  CPU read strobe, active low
- wr_n  in  1  CPU write strobe, active low
- port_addr  in  8  CPU address bits [7:0]
- data_in  in  8  CPU write data (core dout)
- data_out  out  8  read data, valid while data_oe=1
- data_oe  out  1  high while a decoded read access to this block is in progress
- txd  out  1  serial transmit, idle high
- rxd  in  1  serial receive, asynchronous

Behaviour:
- Clocking: single clock domain; all state updates on posedge clk; reset is synchronous active-high.
- Reset values: txd=1, data_oe=0, data_out=0, FIFO empty, all flags 0, TX and RX FSMs IDLE.
- Access decode: sel = ~iorq_n & m1_n & (port_addr==BASE_ADDR or BASE_ADDR+1).
  - Read access: sel & ~rd_n. Write access: sel & ~wr_n.
  - An access spans multiple clk cycles; sel_d is the registered previous value.
- Writes are committed once, on the first cycle of a write access (access true, previous-cycle access false).
- Reads:
  - data_out/data_oe are combinational from current state while the read access is true.
  - Side effects (FIFO pop, flag clear) are committed on the first cycle after the read access ends. This keeps data stable for the whole access.
- Register map:
  - BASE+0 write: TX byte.
  - BASE+0 read: FIFO head (0x00 when empty).
  - BASE+1 read (status): bit0 rx_avail (FIFO non-empty), bit1 tx_busy, bit2 rx_overrun, bit3 framing_err, bits7:4 = 0.
  - BASE+1 write: ignored.
- Data read with an empty FIFO: returns 0x00, no pop.
- Status read: clears rx_overrun and framing_err at access end. A flag set in the same cycle as the clear wins, i.e. stays set.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - Each state lasts CLK_DIV cycles; DATA lasts 8 bit periods, LSB first. txd levels: START=0, STOP=1.
  - Write to BASE+0 in IDLE latches the byte; START begins next cycle.
  - tx_busy=1 from the cycle after the write until STOP completes.
  - Write while tx_busy=1 is dropped, with no flag.
- RX input: rxd passes through a 2-flop synchronizer, preset to 1 on reset.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: on the synchronized falling edge, wait CLK_DIV/2 cycles and resample. If 1, it was a glitch: return to IDLE. If 0, enter DATA.
  - DATA: 8 samples, each CLK_DIV apart, LSB first.
  - STOP: sample once. If 0, set framing_err, discard the byte and return to IDLE. If 1, push the byte.
- FIFO behaviour:
  - Push when full: byte discarded, rx_overrun set, FIFO contents unchanged.
  - Push and pop in the same cycle: both occur, including when full (occupancy unchanged, no overrun).
  - Pointers wrap modulo RX_DEPTH; count width is log2(RX_DEPTH)+1.
- Reset mid-frame aborts both FSMs immediately; txd returns to 1 the next cycle.

Optional Feature:
- Macro: Z80_IO_UART_IRQ_EN.
- Defined:
  - Adds output port int_n (1 bit, active low), to be wired to the core's int_n.
  - int_n=0 while rx_avail=1; registered, so it asserts 1 cycle after the push.
  - Reset value 1.
  - Interrupt-acknowledge cycles (m1_n=0) have no side effects.
- Undefined: port int_n absent; no interrupt logic synthesized.

Test Plan:
1. TX frame: reset, then write 0x55 to port 0x10 (CLK_DIV=16) -> txd low 16 cycles, then 0,1,0,1,0,1,0,1 read LSB-first as 1,0,1,0,1,0,1,0 in 16-cycle bits, stop high; tx_busy reads 1 mid-frame and 0 after 160 cycles.
2. RX frame: drive 0xA3 8N1 at 16 cycles/bit -> status reads 0x01; data read returns 0xA3; next status reads 0x00.
3. Overrun: receive 5 bytes 0x01..0x05 with RX_DEPTH=4, no reads -> status 0x05; data reads return 0x01,0x02,0x03,0x04; following status read 0x00.
4. Framing error: send 0x7E with stop bit held 0 -> no push, status 0x08; second status read 0x00.
5. Glitch and multi-cycle access: a 3-cycle low pulse on rxd -> no RX activity. A 4-cycle read of port 0x10 with 2 bytes queued -> data_out stable for all 4 cycles, exactly one pop. An interrupt-acknowledge cycle (m1_n=0, iorq_n=0) at port 0x10 -> data_oe=0, no pop.
6. Reset and busy write: write 0x12, assert reset at cycle 40 -> txd=1 the following cycle, status 0x00. Write 0x34 then 0x56 back-to-back -> only 0x34 is transmitted.
